data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the core's load/store port: accepts one MEM_* request per handshake, executes it against a
//  word-organised synchronous data RAM and returns a response. Decodes MEM_LB..MEM_SW from my_pkg.
//  Applies byte-lane enables on stores and sign/zero extension on loads. Sits between the MEM stage and data storage.
// PARAMETERS
//  ADDR_WIDTH  32    byte-address width (my_pkg::ADDR_WIDTH)
//  DATA_WIDTH  32    data width; fixed 32, byte lanes = 4
//  DEPTH       4096  RAM depth in words (my_pkg::MEM_DATA_DEPTH); power of 2
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  req_valid  in   1           request present
//  req_ready  out  1           responder can accept
//  req_op     in   3           MEM_LB/LH/LW/LBU/LHU/SB/SH/SW encoding
//  req_addr   in   ADDR_WIDTH  byte address
//  req_wdata  in   DATA_WIDTH  store data, LSB-aligned (SB uses [7:0], SH [15:0])
//  rsp_valid  out  1           response present
//  rsp_ready  in   1           requester accepts response
//  rsp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores/errors
//  rsp_err    out  1           request faulted, no RAM write performed
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; RAM contents not reset.
//  - FSM IDLE->ACCESS->RESP->IDLE. req_ready=1 only in IDLE; transfer on req_valid&req_ready.
//  - Accept (IDLE): latch op, addr, wdata; issue RAM read of word addr[log2(DEPTH)+1:2].
//  - ACCESS (1 cycle): registered read word available; stores perform read-modify-write via byte enables:
//      SB lane=addr[1:0]; SH lanes={addr[1],0}+{0,1}; SW all 4. Faulted requests do not write.
//  - Loads: LB/LBU select byte addr[1:0], LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
//  - RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid&rsp_ready; then IDLE, rsp_valid=0.
//  - Latency: accept at cycle N -> rsp_valid at N+2; min request spacing 3 cycles.
//  - Out-of-range: any addr bit above log2(DEPTH)+1 nonzero -> rsp_err=1, rdata=0, no write.
//  - Load after store to same word returns stored data (write completes in ACCESS before next accept).
//  - req_valid while not ready: ignored, requester must hold. Reset mid-op: response and pending write dropped.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0 -> rsp_err=1, rdata=0, no write.
//  Not defined: misaligned addresses force-aligned (half ignores addr[0], word ignores addr[1:0]), rsp_err=0.
// TESTING
//  - Reset, SW 0x0000_0010 <= 0xDEAD_BEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, err=0, rsp_valid 2 cycles after accept.
//  - SB 0x13 <= 0x80 over 0xDEADBEEF; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
//  - SH 0x22 <= 0x8001 over zeroed word; LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> 0x80010000.
//  - rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0; release -> single transfer, IDLE.
//  - LW 0x0000_4000 (out of range, DEPTH=4096) -> rsp_err=1, rdata=0; word 0 unchanged.
//  - MEM_MISALIGN_CHECK_EN: SW 0x11 -> err=1, no write; undefined: SW 0x11 writes word 0x10, err=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// my_pkg / data_mem_responder
//
// my_pkg carries the shared memory-port constants and the MEM_* operation
// encoding used by the core's MEM stage.
//
// data_mem_responder is the responder end of the core's load/store port. It
// accepts one request per handshake and executes it against a word-organised
// synchronous RAM. It then returns a single response.
//   - Stores use byte-lane enables (read-modify-write of the addressed word).
//   - Loads are sign- or zero-extended.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder can accept (IDLE only)
//   req_op     in   MEM_LB/LH/LW/LBU/LHU/SB/SH/SW
//   req_addr   in   byte address
//   req_wdata  in   store data, LSB-aligned
//   rsp_valid  out  response present
//   rsp_ready  in   requester accepts response
//   rsp_rdata  out  extended load result; 0 for stores and faults
//   rsp_err    out  request faulted, RAM not written
//
// Configuration macro: MEM_MISALIGN_CHECK_EN
//   defined   : misaligned LH/LHU/SH/LW/SW fault (rsp_err=1, no write)
//   undefined : misaligned addresses are force-aligned, rsp_err=0
// ---------------------------------------------------------------------------
package my_pkg;
    localparam int ADDR_WIDTH     = 32;
    localparam int MEM_DATA_DEPTH = 4096;

    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LW  = 3'd2,
        MEM_LBU = 3'd3,
        MEM_LHU = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } mem_op_e;
endpackage

module data_mem_responder
    import my_pkg::*;
#(
    parameter int ADDR_WIDTH = my_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = my_pkg::MEM_DATA_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

    state_e                  state, next_state;
    mem_op_e                 op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    is_store;
    logic                    fault;
    logic [3:0]              byte_en;
    logic [DATA_WIDTH-1:0]   wdata_rep;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic [DATA_WIDTH-1:0]   ld_data;
    logic [7:0]              sel_byte;
    logic [15:0]             sel_half;

    assign accept = req_valid && req_ready;

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = S_ACCESS;
            end
            S_ACCESS: next_state = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------- Request capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= MEM_LB;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q    <= mem_op_e'(req_op);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // ---------------- Access decode ----------------
    always_comb begin
        is_store  = (op_q == MEM_SB) || (op_q == MEM_SH) || (op_q == MEM_SW);
        // Any address bit above the RAM's byte range makes the request fault.
        fault     = (addr_q >> (IDX_W + 2)) != '0;
`ifdef MEM_MISALIGN_CHECK_EN
        case (op_q)
            MEM_LH, MEM_LHU, MEM_SH: if (addr_q[0])          fault = 1'b1;
            MEM_LW, MEM_SW:          if (addr_q[1:0] != 2'b00) fault = 1'b1;
            default: ;
        endcase
`endif
        // Without the check, halves use addr[1] only and words ignore
        // addr[1:0], which gives the force-align behaviour for free.
        sel_byte  = rd_word[{addr_q[1:0], 3'b000} +: 8];
        sel_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

        ld_data   = '0;
        byte_en   = 4'b0000;
        wdata_rep = wdata_q;
        case (op_q)
            MEM_LB:  ld_data = {{24{sel_byte[7]}}, sel_byte};
            MEM_LBU: ld_data = {24'h0, sel_byte};
            MEM_LH:  ld_data = {{16{sel_half[15]}}, sel_half};
            MEM_LHU: ld_data = {16'h0, sel_half};
            MEM_LW:  ld_data = rd_word;
            MEM_SB: begin
                byte_en   = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            MEM_SH: begin
                byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            MEM_SW:  byte_en = 4'b1111;
            default: ;
        endcase

        for (int i = 0; i < 4; i++)
            wr_word[8*i +: 8] = byte_en[i] ? wdata_rep[8*i +: 8] : rd_word[8*i +: 8];
    end

    // ---------------- RAM ----------------
    // NOTE: RAM contents and its read register are deliberately not reset;
    // only control state is, so this maps onto a plain block RAM.
    always_ff @(posedge clk) begin
        if (accept)
            rd_word <= mem[req_addr[IDX_W+1:2]];
        // Write lands at the end of ACCESS, before any following request can
        // be accepted, so a later load of the same word sees it.
        if (state == S_ACCESS && is_store && !fault)
            mem[addr_q[IDX_W+1:2]] <= wr_word;
    end

    // ---------------- Response ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == S_ACCESS) begin
            rsp_rdata <= (fault || is_store) ? '0 : ld_data;
            rsp_err   <= fault;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed and randomized bench for data_mem_responder. Expected results come
// from a byte-addressed reference memory that follows the load/store rules
// (little-endian, extend by size, fault on out-of-range or, with
// MEM_MISALIGN_CHECK_EN, on misalignment; otherwise force-align).
// ---------------------------------------------------------------------------
module tb_data_mem_responder;
    import my_pkg::*;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ref_bytes [int];

    data_mem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: byte memory, little-endian.
    task automatic model(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er);
        int          size;
        bit          sgn;
        bit          st;
        logic [31:0] base;
        logic [31:0] v;
        size = 4; sgn = 0; st = 0;
        case (op)
            MEM_LB:  begin size = 1; sgn = 1; end
            MEM_LH:  begin size = 2; sgn = 1; end
            MEM_LW:  size = 4;
            MEM_LBU: size = 1;
            MEM_LHU: size = 2;
            MEM_SB:  begin size = 1; st = 1; end
            MEM_SH:  begin size = 2; st = 1; end
            default: begin size = 4; st = 1; end
        endcase
        er = (addr >= DEPTH * 4);
`ifdef MEM_MISALIGN_CHECK_EN
        if (addr % size != 0) er = 1'b1;
`endif
        base = addr - (addr % size);
        rd   = '0;
        if (!er) begin
            if (st) begin
                for (int i = 0; i < size; i++) ref_bytes[int'(base) + i] = wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[int'(base) + i]) << (8*i));
                if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rd = v;
            end
        end
    endtask

    // One full transaction with handshake/latency checks, compared to the model.
    task automatic do_op(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall,
                         output logic [31:0] rd, output logic er);
        logic [31:0] m_rd;
        logic        m_er;
        int          waitc;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        rsp_ready = 1'b0;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("accept_ready", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("lat1_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("busy_req_ready", {31'h0, req_ready}, 32'd0);
        @(negedge clk);
        chk("lat2_rsp_valid", {31'h0, rsp_valid}, 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_err", {31'h0, rsp_err}, {31'h0, er});
            chk("hold_req_ready", {31'h0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("done_req_ready", {31'h0, req_ready}, 32'd1);
        model(op, addr, wdata, m_rd, m_er);
        chk("model_rdata", rd, m_rd);
        chk("model_err", {31'h0, er}, {31'h0, m_er});
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [2:0]  rop;
        logic [31:0] raddr;

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'h0, rsp_err}, 32'd0);
        rst_n = 1'b1;

        // Word store / load
        do_op(MEM_SW, 32'h10, 32'hDEAD_BEEF, 0, rd, er);
        chk("sw10_err", {31'h0, er}, 32'd0);
        do_op(MEM_LW, 32'h10, 32'h0, 0, rd, er);
        chk("lw10", rd, 32'hDEAD_BEEF);

        // Byte store in the top lane, loads with both extensions
        do_op(MEM_SB, 32'h13, 32'h0000_0080, 0, rd, er);
        do_op(MEM_LB, 32'h13, 32'h0, 0, rd, er);
        chk("lb13", rd, 32'hFFFF_FF80);
        do_op(MEM_LBU, 32'h13, 32'h0, 0, rd, er);
        chk("lbu13", rd, 32'h0000_0080);
        do_op(MEM_LW, 32'h10, 32'h0, 0, rd, er);
        chk("lw10_after_sb", rd, 32'h80AD_BEEF);

        // Halfword store in upper half of a zeroed word
        do_op(MEM_SW, 32'h20, 32'h0, 0, rd, er);
        do_op(MEM_SH, 32'h22, 32'h0000_8001, 0, rd, er);
        do_op(MEM_LH, 32'h22, 32'h0, 0, rd, er);
        chk("lh22", rd, 32'hFFFF_8001);
        do_op(MEM_LHU, 32'h22, 32'h0, 0, rd, er);
        chk("lhu22", rd, 32'h0000_8001);
        do_op(MEM_LW, 32'h20, 32'h0, 0, rd, er);
        chk("lw20", rd, 32'h8001_0000);

        // Response back-pressure for 5 cycles
        do_op(MEM_LW, 32'h10, 32'h0, 5, rd, er);
        chk("stall_lw10", rd, 32'h80AD_BEEF);

        // Misaligned word store
        do_op(MEM_SW, 32'h11, 32'hCAFE_F00D, 0, rd, er);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("sw11_err", {31'h0, er}, 32'd1);
        do_op(MEM_LW, 32'h10, 32'h0, 0, rd, er);
        chk("lw10_after_sw11", rd, 32'h80AD_BEEF);
`else
        chk("sw11_err", {31'h0, er}, 32'd0);
        do_op(MEM_LW, 32'h10, 32'h0, 0, rd, er);
        chk("lw10_after_sw11", rd, 32'hCAFE_F00D);
`endif

        // Range boundaries
        do_op(MEM_SW, 32'h0, 32'h1234_5678, 0, rd, er);
        do_op(MEM_SW, 32'h3FFC, 32'h5A5A_A5A5, 0, rd, er);
        chk("sw_last_err", {31'h0, er}, 32'd0);
        do_op(MEM_LW, 32'h3FFC, 32'h0, 0, rd, er);
        chk("lw_last", rd, 32'h5A5A_A5A5);
        do_op(MEM_LW, 32'h4000, 32'h0, 0, rd, er);
        chk("lw4000_err", {31'h0, er}, 32'd1);
        chk("lw4000_rdata", rd, 32'h0);
        do_op(MEM_SW, 32'h4000, 32'hFFFF_FFFF, 0, rd, er);
        chk("sw4000_err", {31'h0, er}, 32'd1);
        do_op(MEM_LW, 32'h0, 32'h0, 0, rd, er);
        chk("lw0_unchanged", rd, 32'h1234_5678);

        // Reset during ACCESS drops the pending store
        @(negedge clk);
        req_valid = 1'b1; req_op = MEM_SW; req_addr = 32'h0; req_wdata = 32'hAAAA_AAAA;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(MEM_LW, 32'h0, 32'h0, 0, rd, er);
        chk("lw0_after_midrst", rd, 32'h1234_5678);

        // Randomized traffic over the first 64 words plus out-of-range hits
        for (int w = 0; w < 64; w++)
            do_op(MEM_SW, 32'(w * 4), $urandom(), 0, rd, er);
        for (int n = 0; n < 200; n++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       raddr = 32'h4000 + $urandom_range(0, 255);
                1:       raddr = $urandom() | 32'h8000_0000;
                default: raddr = $urandom_range(0, 255);
            endcase
            do_op(rop, raddr, $urandom(), $urandom_range(0, 2), rd, er);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
